// File: rtl/bullet_scheduler_pkg.sv
// Shared game constants and scheduler types: bullet geometry, burst timing defaults, FSM states.
package bullet_scheduler_pkg;

   localparam int unsigned BULLET_W      = 4;
   localparam int unsigned BULLET_H      = 8;
   localparam int unsigned BULLET_SPEED  = 2;

   localparam int unsigned NUM_SLOTS_DEF = 4;
   localparam int unsigned BURST_LEN_DEF = 3;
   localparam int unsigned BURST_GAP_DEF = 8;
   localparam int unsigned COOLDOWN_DEF  = 30;
   localparam int unsigned HIT_CNT_W     = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIRE = 2'd1,
      GAP  = 2'd2,
      COOL = 2'd3
   } sched_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bullet_scheduler_slot_picker.sv
// Combinational priority encoder: one-hot of the lowest-index available slot plus a found flag.
module bullet_scheduler_slot_picker #(
   parameter int unsigned NUM_SLOTS = 4
) (
   input  logic [NUM_SLOTS-1:0] avail,
   output logic [NUM_SLOTS-1:0] onehot,
   output logic                 found
);

   always_comb begin
      onehot = '0;
      found  = 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (avail[i] && !found) begin
            onehot[i] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bullet_scheduler.sv
// Enemy burst-fire scheduler: accepts fire requests, launches bursts into free bullet slots, counts hits.
module bullet_scheduler
   import bullet_scheduler_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEF,
   parameter int unsigned BURST_LEN = BURST_LEN_DEF,
   parameter int unsigned BURST_GAP = BURST_GAP_DEF,
   parameter int unsigned COOLDOWN  = COOLDOWN_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 frame_tick,
   input  logic                 fire_req,
   input  logic                 defend,
   input  logic [NUM_SLOTS-1:0] slot_busy,
   input  logic [NUM_SLOTS-1:0] slot_hit,
   output logic [NUM_SLOTS-1:0] attack,
   output logic                 fire_ack,
   output logic                 busy,
   output logic [7:0]           hit_cnt
);

   localparam int unsigned CNT_W   = $clog2(max_u(BURST_GAP, COOLDOWN) + 1);
   localparam int unsigned SHOTS_W = $clog2(BURST_LEN + 1);
   localparam int unsigned SUM_W   = 16;

   sched_state_e         state;
   logic [SHOTS_W-1:0]   shots_left;
   logic [CNT_W-1:0]     tick_cnt;
   logic [NUM_SLOTS-1:0] avail;
   logic [NUM_SLOTS-1:0] pick_onehot;
   logic                 pick_found;
   logic [SUM_W-1:0]     hit_sum;
   logic [7:0]           hit_next;

   // The slot pulsed this cycle has not raised slot_busy yet, so mask it out.
   assign avail = ~(slot_busy | attack);

   bullet_scheduler_slot_picker #(
      .NUM_SLOTS (NUM_SLOTS)
   ) u_picker (
      .avail  (avail),
      .onehot (pick_onehot),
      .found  (pick_found)
   );

   // Saturating hit accumulation; every simultaneous hit counts.
   always_comb begin
      hit_sum = SUM_W'(hit_cnt);
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         hit_sum = hit_sum + SUM_W'(slot_hit[i]);
      end
      hit_next = (hit_sum > SUM_W'(255)) ? 8'hFF : hit_sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         attack     <= '0;
         fire_ack   <= 1'b0;
         busy       <= 1'b0;
         hit_cnt    <= '0;
         shots_left <= '0;
         tick_cnt   <= '0;
      end else begin
         attack   <= '0;
         fire_ack <= 1'b0;
         hit_cnt  <= hit_next;
         case (state)
            IDLE: begin
               if (fire_req && !defend) begin
                  state      <= FIRE;
                  fire_ack   <= 1'b1;
                  busy       <= 1'b1;
                  shots_left <= SHOTS_W'(BURST_LEN);
               end
            end
            FIRE: begin
               if (frame_tick && !defend && pick_found) begin
                  attack     <= pick_onehot;
                  shots_left <= shots_left - 1'b1;
                  tick_cnt   <= '0;
                  state      <= (shots_left > SHOTS_W'(1)) ? GAP : COOL;
               end
            end
            GAP: begin
               if (frame_tick) begin
                  if ((tick_cnt + 1'b1) >= CNT_W'(BURST_GAP)) begin
                     state    <= FIRE;
                     tick_cnt <= '0;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            COOL: begin
               if (frame_tick) begin
                  if ((tick_cnt + 1'b1) >= CNT_W'(COOLDOWN)) begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     tick_cnt <= '0;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bullet_scheduler.sv
// Self-checking bench for bullet_scheduler: directed scenarios plus random traffic against a tick-level model.
module tb_bullet_scheduler;

   localparam int BURST_LEN = 3;
   localparam int BURST_GAP = 8;
   localparam int COOLDOWN  = 30;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       frame_tick;
   logic       fire_req;
   logic       defend;
   logic [3:0] slot_busy;
   logic [3:0] slot_hit;
   logic [3:0] attack;
   logic       fire_ack;
   logic       busy;
   logic [7:0] hit_cnt;

   int checks = 0;
   int errors = 0;

   // Model: burst in progress flag, shots already fired, frame ticks still to wait.
   bit         m_active;
   int         m_fired;
   int         m_wait;
   int         m_hits;
   logic [3:0] exp_attack;
   logic       exp_ack;
   logic       exp_busy;
   bit         model_valid = 0;

   int         n_shot, n_ack, n_ticks, ticks_at_first;
   logic [3:0] first_attack;
   int         life [4];

   always #5 clk = ~clk;

   bullet_scheduler dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .fire_req   (fire_req),
      .defend     (defend),
      .slot_busy  (slot_busy),
      .slot_hit   (slot_hit),
      .attack     (attack),
      .fire_ack   (fire_ack),
      .busy       (busy),
      .hit_cnt    (hit_cnt)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic rn, ft, fr, df, input logic [3:0] sb, sh);
      logic [3:0] new_att;
      bit         found;
      new_att = '0;
      found   = 0;
      exp_ack = 1'b0;
      if (!rn) begin
         m_active = 0;
         m_fired  = 0;
         m_wait   = 0;
         m_hits   = 0;
      end else begin
         m_hits = m_hits + $countones(sh);
         if (m_hits > 255) m_hits = 255;
         if (!m_active) begin
            if (fr && !df) begin
               m_active = 1;
               m_fired  = 0;
               m_wait   = 0;
               exp_ack  = 1'b1;
            end
         end else if (m_wait > 0) begin
            if (ft) m_wait--;
            if (m_wait == 0 && m_fired == BURST_LEN) m_active = 0;
         end else if (ft && !df) begin
            for (int i = 0; i < 4; i++) begin
               if (!found && !sb[i] && !exp_attack[i]) begin
                  found      = 1;
                  new_att[i] = 1'b1;
               end
            end
            if (found) begin
               m_fired++;
               m_wait = (m_fired == BURST_LEN) ? COOLDOWN : BURST_GAP;
            end
         end
      end
      exp_attack = new_att;
      exp_busy   = m_active;
   endtask

   task automatic cycle(input logic rn, ft, fr, df, input logic [3:0] sb, sh);
      @(negedge clk);
      if (model_valid) begin
         check("attack",   32'(attack),   32'(exp_attack));
         check("fire_ack", 32'(fire_ack), 32'(exp_ack));
         check("busy",     32'(busy),     32'(exp_busy));
         check("hit_cnt",  32'(hit_cnt),  32'(m_hits));
      end
      if (attack != 4'b0) begin
         n_shot++;
         if (first_attack == 4'b0) begin
            first_attack   = attack;
            ticks_at_first = n_ticks;
         end
      end
      if (fire_ack) n_ack++;
      for (int i = 0; i < 4; i++) begin
         if (attack[i]) life[i] = 12;
         else if (life[i] > 0) life[i]--;
      end
      rst_n      = rn;
      frame_tick = ft;
      fire_req   = fr;
      defend     = df;
      slot_busy  = sb;
      slot_hit   = sh;
      if (ft) n_ticks++;
      model_step(rn, ft, fr, df, sb, sh);
      model_valid = 1;
   endtask

   task automatic clear_obs();
      n_shot       = 0;
      n_ack        = 0;
      n_ticks      = 0;
      first_attack = 4'b0;
      ticks_at_first = 0;
   endtask

   task automatic do_reset();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0);
   endtask

   initial begin
      logic [3:0] sb;
      for (int i = 0; i < 4; i++) life[i] = 0;
      clear_obs();
      do_reset();

      // Scenario 1: full burst with slot_busy following launches
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0);
      check("reset_busy", 32'(busy), 32'(0));
      check("reset_hits", 32'(hit_cnt), 32'(0));
      clear_obs();
      for (int c = 0; c < 620; c++) begin
         for (int i = 0; i < 4; i++) sb[i] = (life[i] > 0);
         cycle(1'b1, (c % 10 == 9), (c == 2), 1'b0, sb, 4'b0);
      end
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0);
      check("s1_acks", 32'(n_ack), 32'(1));
      check("s1_shots", 32'(n_shot), 32'(3));
      check("s1_first", 32'(first_attack), 32'(1));
      check("s1_busy_fall", 32'(busy), 32'(0));

      // Scenario 2: all slots busy for three ticks, then only slot 2 free
      do_reset();
      clear_obs();
      for (int c = 0; c < 40; c++) begin
         sb = (c >= 1 && n_ticks < 3) ? 4'b1111 : 4'b1011;
         cycle(1'b1, (c % 5 == 4), (c == 0), 1'b0, sb, 4'b0);
      end
      check("s2_first", 32'(first_attack), 32'(4'b0100));
      check("s2_tick", 32'(ticks_at_first), 32'(4));

      // Scenario 3: defend blocks acceptance, then holds the launch
      do_reset();
      clear_obs();
      for (int c = 0; c < 10; c++) cycle(1'b1, (c % 3 == 0), 1'b1, 1'b1, 4'b0, 4'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0);
      check("s3_no_ack", 32'(n_ack), 32'(0));
      check("s3_idle", 32'(busy), 32'(0));
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'b0, 4'b0);
      for (int c = 0; c < 25; c++) cycle(1'b1, (c % 5 == 2), 1'b0, 1'b1, 4'b0, 4'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0);
      check("s3_held", 32'(n_shot), 32'(0));
      for (int c = 0; c < 10; c++) cycle(1'b1, (c % 5 == 2), 1'b0, 1'b0, 4'b0, 4'b0);
      check("s3_released", 32'(n_shot), 32'(1));

      // Scenario 4: hit counter saturation
      do_reset();
      for (int c = 0; c < 70; c++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b1111);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b1111);
      check("s4_sat", 32'(hit_cnt), 32'(255));
      for (int c = 0; c < 5; c++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0101);
      check("s4_nowrap", 32'(hit_cnt), 32'(255));

      // Scenario 5: reset during the gap after one shot, then a fresh full burst
      do_reset();
      clear_obs();
      for (int c = 0; c < 20; c++) cycle(1'b1, (c % 4 == 3), (c == 0), 1'b0, 4'b0, 4'b0);
      check("s5_one_shot", 32'(n_shot), 32'(1));
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'b0, 4'b0);
      check("s5_rst_busy", 32'(busy), 32'(0));
      check("s5_rst_attack", 32'(attack), 32'(0));
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0);
      check("s5_no_launch", 32'(attack), 32'(0));
      clear_obs();
      for (int c = 0; c < 260; c++) cycle(1'b1, (c % 4 == 3), (c == 0), 1'b0, 4'b0, 4'b0);
      check("s5_full_burst", 32'(n_shot), 32'(3));

      // Scenario 6: frame_tick coincident with acceptance does not launch
      do_reset();
      clear_obs();
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'b0, 4'b0);
      for (int c = 0; c < 20; c++) cycle(1'b1, (c % 6 == 5), 1'b0, 1'b0, 4'b0, 4'b0);
      check("s6_first_tick", 32'(ticks_at_first), 32'(2));

      // Random traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         cycle(($urandom_range(0, 499) != 0),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 9) < 3),
               ($urandom_range(0, 6) == 0),
               4'($urandom),
               ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0);
      end
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
